// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU for the SISC datapath.
// Single-cycle add/logic/shift/rotate ops finish one edge after start;
// MUL/MULH (and DIV/REM when SISC_ALU_DIV_EN is defined) run one iteration
// per cycle for WIDTH cycles behind a busy/done handshake.
// Result and {C,V,N,Z} status are registered together and held until the
// next done pulse. Without SISC_ALU_DIV_EN the divide codes act as reserved.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int IMM_W = 16
) (
    input  logic             clk,
    input  logic             rst_f,
    input  logic             start,
    input  logic [WIDTH-1:0] rsa,
    input  logic [WIDTH-1:0] rsb,
    input  logic [IMM_W-1:0] imm,
    input  logic             c_in,
    input  logic [3:0]       alu_op,
    input  logic [4:0]       funct,
    output logic [WIDTH-1:0] alu_result,
    output logic [3:0]       stat,
    output logic [3:0]       stat_en,
    output logic             busy,
    output logic             done
);

    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [4:0] F_ADD  = 5'b00001;
    localparam logic [4:0] F_SUB  = 5'b00010;
    localparam logic [4:0] F_ADC  = 5'b00011;
    localparam logic [4:0] F_NOT  = 5'b00100;
    localparam logic [4:0] F_OR   = 5'b00101;
    localparam logic [4:0] F_AND  = 5'b00110;
    localparam logic [4:0] F_XOR  = 5'b00111;
    localparam logic [4:0] F_ROR  = 5'b01000;
    localparam logic [4:0] F_ROL  = 5'b01001;
    localparam logic [4:0] F_SHR  = 5'b01010;
    localparam logic [4:0] F_SHL  = 5'b01011;
    localparam logic [4:0] F_RRC  = 5'b01100;
    localparam logic [4:0] F_RLC  = 5'b01101;
    localparam logic [4:0] F_ASR  = 5'b01110;
    localparam logic [4:0] F_ASL  = 5'b01111;
    localparam logic [4:0] F_MUL  = 5'b10000;
    localparam logic [4:0] F_MULH = 5'b10001;
`ifdef SISC_ALU_DIV_EN
    localparam logic [4:0] F_DIV  = 5'b10010;
    localparam logic [4:0] F_REM  = 5'b10011;
`endif

    typedef enum logic {
        S_IDLE,
        S_ITER
    } state_e;

    // Registered state
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;       // MUL high half / DIV partial remainder
    logic [WIDTH-1:0]   mq_q, mq_d;         // multiplier -> low half / dividend -> quotient
    logic [WIDTH-1:0]   mcand_q, mcand_d;   // multiplicand / divisor
    logic               hi_q, hi_d;         // 1: deliver acc (MULH/REM), 0: deliver mq (MUL/DIV)
    logic               upd_q, upd_d;       // status-update request captured at start
`ifdef SISC_ALU_DIV_EN
    logic               div_q, div_d;
    logic               dz_q, dz_d;
`endif
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         stat_q, stat_d;
    logic [3:0]         stat_en_q, stat_en_d;
    logic               done_q, done_d;

    // Operand and decode signals
    logic [WIDTH-1:0]   imm_ext;
    logic [WIDTH-1:0]   opb;
    logic               funct_mode;
    logic               iter_req;
    logic [SH_W-1:0]    sh;
    logic [31:0]        sh32;

    assign imm_ext    = WIDTH'($signed(imm));
    assign opb        = (alu_op[3:1] == 3'b001) ? imm_ext : rsb;
    assign funct_mode = (alu_op[3:2] == 2'b00);
    assign sh         = opb[SH_W-1:0];
    assign sh32       = 32'(sh);

`ifdef SISC_ALU_DIV_EN
    assign iter_req = funct_mode && (funct == F_MUL || funct == F_MULH ||
                                     funct == F_DIV || funct == F_REM);
`else
    assign iter_req = funct_mode && (funct == F_MUL || funct == F_MULH);
`endif

    // Shift/rotate datapaths. Shifts carry an extra guard bit so the last bit
    // shifted out lands in a fixed position (0 when the amount is 0).
    logic [WIDTH-1:0]   ror_r, rol_r;
    logic [WIDTH:0]     shr_x, shl_x, asr_x, rot_v, rrc_v, rlc_v;

    assign ror_r = (rsa >> sh) | (rsa << (32'(WIDTH) - sh32));
    assign rol_r = (rsa << sh) | (rsa >> (32'(WIDTH) - sh32));
    assign shr_x = {rsa, 1'b0} >> sh;
    assign shl_x = {1'b0, rsa} << sh;
    assign asr_x = $signed({rsa, 1'b0}) >>> sh;
    assign rot_v = {c_in, rsa};
    assign rrc_v = (rot_v >> sh) | (rot_v << (32'(WIDTH + 1) - sh32));
    assign rlc_v = (rot_v << sh) | (rot_v >> (32'(WIDTH + 1) - sh32));

    function automatic logic ovf_add(logic a, logic b, logic r);
        return (a == b) && (r != a);
    endfunction

    function automatic logic ovf_sub(logic a, logic b, logic r);
        return (a != b) && (r != a);
    endfunction

    logic [WIDTH-1:0]   sc_res;
    logic               sc_c, sc_v;
    logic [3:0]         sc_mask;
    logic [WIDTH:0]     add_x;

    // Single-cycle result, carry/overflow and status-enable mask
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        sc_res  = '0;
        sc_c    = 1'b0;
        sc_v    = 1'b0;
        sc_mask = 4'b0000;
        add_x   = '0;
        if (funct_mode) begin
            case (funct)
                F_ADD: begin
                    add_x   = {1'b0, rsa} + {1'b0, opb};
                    sc_res  = add_x[WIDTH-1:0];
                    sc_c    = add_x[WIDTH];
                    sc_v    = ovf_add(rsa[WIDTH-1], opb[WIDTH-1], sc_res[WIDTH-1]);
                    sc_mask = 4'b1111;
                end
                F_SUB: begin
                    add_x   = {1'b0, rsa} - {1'b0, opb};
                    sc_res  = add_x[WIDTH-1:0];
                    sc_c    = add_x[WIDTH];
                    sc_v    = ovf_sub(rsa[WIDTH-1], opb[WIDTH-1], sc_res[WIDTH-1]);
                    sc_mask = 4'b1111;
                end
                F_ADC: begin
                    add_x   = {1'b0, rsa} + {1'b0, opb} + {{WIDTH{1'b0}}, c_in};
                    sc_res  = add_x[WIDTH-1:0];
                    sc_c    = add_x[WIDTH];
                    sc_v    = ovf_add(rsa[WIDTH-1], opb[WIDTH-1], sc_res[WIDTH-1]);
                    sc_mask = 4'b1111;
                end
                F_NOT: begin sc_res = ~rsa;       sc_mask = 4'b0011; end
                F_OR:  begin sc_res = rsa | opb;  sc_mask = 4'b0011; end
                F_AND: begin sc_res = rsa & opb;  sc_mask = 4'b0011; end
                F_XOR: begin sc_res = rsa ^ opb;  sc_mask = 4'b0011; end
                F_ROR: begin
                    sc_res  = ror_r;
                    sc_c    = (sh != '0) && ror_r[WIDTH-1];
                    sc_mask = 4'b0011;
                end
                F_ROL: begin
                    sc_res  = rol_r;
                    sc_c    = (sh != '0) && rol_r[0];
                    sc_mask = 4'b0011;
                end
                F_SHR: begin sc_res = shr_x[WIDTH:1];   sc_c = shr_x[0];     sc_mask = 4'b0011; end
                F_SHL: begin sc_res = shl_x[WIDTH-1:0]; sc_c = shl_x[WIDTH]; sc_mask = 4'b0011; end
                F_RRC: begin sc_res = rrc_v[WIDTH-1:0]; sc_c = rrc_v[WIDTH]; sc_mask = 4'b1011; end
                F_RLC: begin sc_res = rlc_v[WIDTH-1:0]; sc_c = rlc_v[WIDTH]; sc_mask = 4'b1011; end
                F_ASR: begin sc_res = asr_x[WIDTH:1];   sc_c = asr_x[0];     sc_mask = 4'b1011; end
                F_ASL: begin sc_res = shl_x[WIDTH-1:0]; sc_c = shl_x[WIDTH]; sc_mask = 4'b1011; end
                default: ; // none / reserved: result 0, no status update
            endcase
        end else begin
            sc_mask = 4'b1011;
            case (alu_op[3:1])
                3'b010: begin
                    add_x  = {1'b0, rsa} + {1'b0, imm_ext};
                    sc_res = add_x[WIDTH-1:0];
                    sc_c   = add_x[WIDTH];
                    sc_v   = ovf_add(rsa[WIDTH-1], imm_ext[WIDTH-1], sc_res[WIDTH-1]);
                end
                3'b011: begin
                    add_x  = {1'b0, rsa} - {1'b0, imm_ext};
                    sc_res = add_x[WIDTH-1:0];
                    sc_c   = add_x[WIDTH];
                    sc_v   = ovf_sub(rsa[WIDTH-1], imm_ext[WIDTH-1], sc_res[WIDTH-1]);
                end
                3'b100: begin
                    add_x  = {1'b0, rsa} + 1'b1;
                    sc_res = add_x[WIDTH-1:0];
                    sc_c   = add_x[WIDTH];
                    sc_v   = ovf_add(rsa[WIDTH-1], 1'b0, sc_res[WIDTH-1]);
                end
                3'b101: begin
                    add_x  = {1'b0, rsa} - 1'b1;
                    sc_res = add_x[WIDTH-1:0];
                    sc_c   = add_x[WIDTH];
                    sc_v   = ovf_sub(rsa[WIDTH-1], 1'b0, sc_res[WIDTH-1]);
                end
                3'b110:  sc_res = rsa;
                default: sc_res = rsb;
            endcase
        end
    end

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   step_acc, step_mq, fin_res;
    logic               fin_v;
    logic [3:0]         fin_mask;
`ifdef SISC_ALU_DIV_EN
    logic [WIDTH:0]     div_shift, div_diff;
`endif

    // One shift-add (MUL) or restoring-subtract (DIV) iteration
    always_comb begin
        mul_sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mcand_q} : '0);
        step_acc = mul_sum[WIDTH:1];
        step_mq  = {mul_sum[0], mq_q[WIDTH-1:1]};
        fin_v    = 1'b0;
        fin_mask = 4'b0011;
`ifdef SISC_ALU_DIV_EN
        // A zero divisor always "fits", giving all-ones quotient and remainder = dividend.
        div_shift = {acc_q, mq_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mcand_q};
        if (div_q) begin
            fin_v    = dz_q;
            fin_mask = 4'b0111;
            if (!div_diff[WIDTH]) begin
                step_acc = div_diff[WIDTH-1:0];
                step_mq  = {mq_q[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = div_shift[WIDTH-1:0];
                step_mq  = {mq_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
        fin_res = hi_q ? step_acc : step_mq;
    end

    // FSM next state, iteration registers and result/status capture
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        upd_d     = upd_q;
`ifdef SISC_ALU_DIV_EN
        div_d     = div_q;
        dz_d      = dz_q;
`endif
        result_d  = result_q;
        stat_d    = stat_q;
        stat_en_d = 4'b0000;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (iter_req) begin
                        state_d = S_ITER;
                        cnt_d   = CNT_W'(WIDTH);
                        acc_d   = '0;
                        mq_d    = rsa;
                        mcand_d = opb;
                        hi_d    = funct[0];
                        upd_d   = alu_op[0];
`ifdef SISC_ALU_DIV_EN
                        div_d   = funct[1];
                        dz_d    = (opb == '0);
`endif
                    end else begin
                        result_d  = sc_res;
                        stat_d    = {sc_c, sc_v, sc_res[WIDTH-1], (sc_res == '0)};
                        stat_en_d = alu_op[0] ? sc_mask : 4'b0000;
                        done_d    = 1'b1;
                    end
                end
            end
            default: begin
                acc_d = step_acc;
                mq_d  = step_mq;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = S_IDLE;
                    result_d  = fin_res;
                    stat_d    = {1'b0, fin_v, fin_res[WIDTH-1], (fin_res == '0)};
                    stat_en_d = upd_q ? fin_mask : 4'b0000;
                    done_d    = 1'b1;
                end
            end
        endcase
    end

    // State registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            mcand_q   <= '0;
            hi_q      <= 1'b0;
            upd_q     <= 1'b0;
`ifdef SISC_ALU_DIV_EN
            div_q     <= 1'b0;
            dz_q      <= 1'b0;
`endif
            result_q  <= '0;
            stat_q    <= '0;
            stat_en_q <= '0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            upd_q     <= upd_d;
`ifdef SISC_ALU_DIV_EN
            div_q     <= div_d;
            dz_q      <= dz_d;
`endif
            result_q  <= result_d;
            stat_q    <= stat_d;
            stat_en_q <= stat_en_d;
            done_q    <= done_d;
        end
    end

    assign alu_result = result_q;
    assign stat       = stat_q;
    assign stat_en    = stat_en_q;
    assign busy       = (state_q == S_ITER);
    assign done       = done_q;

endmodule
